// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus target between NumReq requesters.
// Optional watchdog compiled in with `define XALP_REG_ARB_TIMEOUT_EN.
module reg_bus_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  input  logic [NumReq-1:0]                    req_write_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   req_wstrb_i,
  output logic [NumReq-1:0]                    req_ready_o,
  output logic [NumReq-1:0][DataWidth-1:0]     req_rdata_o,
  output logic [NumReq-1:0]                    req_error_o,
  output logic                                 tgt_valid_o,
  output logic                                 tgt_write_o,
  output logic [AddrWidth-1:0]                 tgt_addr_o,
  output logic [DataWidth-1:0]                 tgt_wdata_o,
  output logic [DataWidth/8-1:0]               tgt_wstrb_o,
  input  logic                                 tgt_ready_i,
  input  logic [DataWidth-1:0]                 tgt_rdata_i,
  input  logic                                 tgt_error_i,
  output logic [NumReq-1:0]                    grant_o,
  output logic                                 busy_o,
  output logic                                 timeout_o,
  input  logic                                 timeout_clr_i
);

  localparam int unsigned IdxW  = $clog2(NumReq);
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_r;
  logic [NumReq-1:0]       grant_r;
  logic [IdxW-1:0]         grant_idx_r;
  logic [IdxW-1:0]         ptr_r;
  logic                    busy_r;

  logic                    busy_s;
  logic                    g_valid_s;
  logic                    done_s;
  logic                    abort_s;
  logic                    expire_s;
  logic                    end_s;
  logic [IdxW-1:0]         pick_s;
  logic [IdxW-1:0]         next_ptr_s;

  // First valid index at or after ptr, wrapping modulo NumReq.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] valid,
                                              input logic [IdxW-1:0]   ptr);
    logic [IdxW-1:0] idx;
    int unsigned     best_off;
    int unsigned     off;
    idx      = ptr;
    best_off = NumReq;
    for (int unsigned c = 0; c < NumReq; c++) begin
      off = (c + NumReq - 32'(ptr)) % NumReq;
      if (valid[c] && (off < best_off)) begin
        best_off = off;
        idx      = IdxW'(c);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign busy_s     = (state_r == BUSY);
  assign g_valid_s  = req_valid_i[grant_idx_r];
  assign pick_s     = rr_pick(req_valid_i, ptr_r);
  assign next_ptr_s = (grant_idx_r == IdxW'(NumReq - 1)) ? '0 : grant_idx_r + IdxW'(1);
  assign done_s     = busy_s & tgt_ready_i;
  assign abort_s    = busy_s & ~tgt_ready_i & ~g_valid_s;
  assign end_s      = done_s | abort_s | expire_s;

`ifdef XALP_REG_ARB_TIMEOUT_EN
  localparam int unsigned          CntW         = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0]      CntLast      = CntW'(TimeoutCycles - 1);
  localparam logic [31:0]          TimeoutWord  = 32'hBADCAB1E;
  localparam logic [DataWidth-1:0] TimeoutRdata = DataWidth'(TimeoutWord);

  logic [CntW-1:0] wd_cnt_r;
  logic            timeout_r;

  // A still-requested transaction that reaches the limit without ready is terminated.
  assign expire_s  = busy_s & ~tgt_ready_i & g_valid_s & (wd_cnt_r == CntLast);
  assign timeout_o = timeout_r;

  // Watchdog counter and sticky timeout flag; expiry beats a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && (|req_valid_i)) begin
        wd_cnt_r <= '0;
      end else if (busy_s && !tgt_ready_i && (wd_cnt_r != CntLast)) begin
        wd_cnt_r <= wd_cnt_r + CntW'(1);
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      if (expire_s) begin
        timeout_r <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end
`else
  logic unused_s;

  assign expire_s  = 1'b0;
  assign timeout_o = 1'b0;
  assign unused_s  = timeout_clr_i ^ (TimeoutCycles == 32'd0);
`endif

  // Target request forwarding and response routing to the granted requester.
  always_comb begin
    req_ready_o = '0;
    req_rdata_o = '0;
    req_error_o = '0;
    tgt_valid_o = 1'b0;
    tgt_write_o = 1'b0;
    tgt_addr_o  = '0;
    tgt_wdata_o = '0;
    tgt_wstrb_o = {StrbW{1'b0}};
    if (busy_s) begin
      tgt_valid_o = g_valid_s & ~expire_s;
      tgt_write_o = req_write_i[grant_idx_r];
      tgt_addr_o  = req_addr_i[grant_idx_r];
      tgt_wdata_o = req_wdata_i[grant_idx_r];
      tgt_wstrb_o = req_wstrb_i[grant_idx_r];
      req_ready_o[grant_idx_r] = tgt_ready_i | expire_s;
      req_error_o[grant_idx_r] = tgt_error_i | expire_s;
`ifdef XALP_REG_ARB_TIMEOUT_EN
      req_rdata_o[grant_idx_r] = expire_s ? TimeoutRdata : tgt_rdata_i;
`else
      req_rdata_o[grant_idx_r] = tgt_rdata_i;
`endif
    end else begin
      tgt_valid_o = 1'b0;
    end
  end

  // Arbitration FSM: grant in IDLE, hold through BUSY, rotate pointer on exit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      grant_idx_r <= '0;
      ptr_r       <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_valid_i) begin
            state_r     <= BUSY;
            grant_idx_r <= pick_s;
            grant_r     <= NumReq'(1) << pick_s;
            busy_r      <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (end_s) begin
            state_r <= IDLE;
            grant_r <= '0;
            busy_r  <= 1'b0;
            ptr_r   <= next_ptr_s;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o = grant_r;
  assign busy_o  = busy_r;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed self-checking bench for reg_bus_arbiter (NumReq=2, TimeoutCycles=8).
module tb_reg_bus_arbiter;

  logic             clk;
  logic             rst_i;
  logic [1:0]       req_valid;
  logic [1:0]       req_write;
  logic [1:0][63:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_wstrb;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_rdata;
  logic [1:0]       req_error;
  logic             tgt_valid;
  logic             tgt_write;
  logic [63:0]      tgt_addr;
  logic [31:0]      tgt_wdata;
  logic [3:0]       tgt_wstrb;
  logic             tgt_ready;
  logic [31:0]      tgt_rdata;
  logic             tgt_error;
  logic [1:0]       grant;
  logic             busy;
  logic             timeout;
  logic             timeout_clr;

  int check_cnt = 0;
  int error_cnt = 0;

  reg_bus_arbiter #(
    .NumReq(2), .AddrWidth(64), .DataWidth(32), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .req_ready_o(req_ready), .req_rdata_o(req_rdata), .req_error_o(req_error),
    .tgt_valid_o(tgt_valid), .tgt_write_o(tgt_write), .tgt_addr_o(tgt_addr),
    .tgt_wdata_o(tgt_wdata), .tgt_wstrb_o(tgt_wstrb),
    .tgt_ready_i(tgt_ready), .tgt_rdata_i(tgt_rdata), .tgt_error_i(tgt_error),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout), .timeout_clr_i(timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  logic [1:0] exp_g;

  initial begin
    rst_i = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; tgt_ready = 1'b0; tgt_rdata = '0;
    tgt_error = 1'b0; timeout_clr = 1'b0;
    #2;
    check_eq("rst_grant", grant, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_tgt_valid", tgt_valid, 1'b0);
    check_eq("rst_ready", req_ready, 2'b00);
    check_eq("rst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;

    // Single read from requester 0
    @(negedge clk);
    req_valid = 2'b01; req_addr[0] = 64'h10000;
    #1;
    check_eq("rd_idle_tgt_valid", tgt_valid, 1'b0);
    @(negedge clk);
    tgt_ready = 1'b1; tgt_rdata = 32'h1234_5678;
    #1;
    check_eq("rd_tgt_valid", tgt_valid, 1'b1);
    check_eq("rd_tgt_addr", tgt_addr, 64'h10000);
    check_eq("rd_tgt_write", tgt_write, 1'b0);
    check_eq("rd_grant", grant, 2'b01);
    check_eq("rd_ready", req_ready, 2'b01);
    check_eq("rd_rdata0", req_rdata[0], 32'h1234_5678);
    check_eq("rd_rdata1", req_rdata[1], 32'h0);
    @(negedge clk);
    req_valid = 2'b00; tgt_ready = 1'b0;
    #1;
    check_eq("rd_grant_clr", grant, 2'b00);
    check_eq("rd_busy_clr", busy, 1'b0);
    pulse_reset();

    // Round-robin with both requesters valid and a zero-wait target
    @(negedge clk);
    req_valid = 2'b11; tgt_ready = 1'b1; tgt_rdata = 32'h5A;
    for (int t = 0; t < 12; t++) begin
      if (t != 0) @(negedge clk);
      #1;
      exp_g = (t % 2 == 1) ? (((t / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check_eq($sformatf("rr_grant_%0d", t), grant, exp_g);
      check_eq($sformatf("rr_ready_%0d", t), req_ready, exp_g);
    end
    @(negedge clk);
    req_valid = 2'b00; tgt_ready = 1'b0;

    // Stall: requester 1 held pending while requester 0 waits 5 cycles
    @(negedge clk);
    req_valid = 2'b11;
    for (int t = 1; t < 5; t++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("st_grant_%0d", t), grant, 2'b01);
      check_eq($sformatf("st_ready_%0d", t), req_ready, 2'b00);
    end
    @(negedge clk);
    tgt_ready = 1'b1;
    #1;
    check_eq("st_ready0", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10; tgt_ready = 1'b0;
    #1;
    check_eq("st_idle_gap", grant, 2'b00);
    @(negedge clk);
    tgt_ready = 1'b1;
    #1;
    check_eq("st_grant1", grant, 2'b10);
    check_eq("st_ready1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00; tgt_ready = 1'b0;

    // Abort: requester 0 withdraws, pointer advances, wrap picks 0 again
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk);
    #1;
    check_eq("ab_tgt_valid", tgt_valid, 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_eq("ab_tgt_valid_drop", tgt_valid, 1'b0);
    check_eq("ab_no_ready", req_ready, 2'b00);
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    check_eq("ab_idle", grant, 2'b00);
    @(negedge clk);
    tgt_ready = 1'b1;
    #1;
    check_eq("ab_wrap_grant", grant, 2'b01);
    check_eq("ab_wrap_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00; tgt_ready = 1'b0;

`ifdef XALP_REG_ARB_TIMEOUT_EN
    // Watchdog expiry at the 8th BUSY cycle
    @(negedge clk);
    req_valid = 2'b01;
    for (int t = 1; t < 8; t++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("wd_ready_%0d", t), req_ready, 2'b00);
      check_eq($sformatf("wd_timeout_%0d", t), timeout, 1'b0);
    end
    @(negedge clk);
    #1;
    check_eq("wd_ready", req_ready, 2'b01);
    check_eq("wd_error", req_error, 2'b01);
    check_eq("wd_rdata", req_rdata[0], 32'hBADCAB1E);
    check_eq("wd_tgt_valid", tgt_valid, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_eq("wd_sticky", timeout, 1'b1);
    check_eq("wd_grant_clr", grant, 2'b00);
    @(negedge clk);
    timeout_clr = 1'b1;
    #1;
    check_eq("wd_still_set", timeout, 1'b1);
    @(negedge clk);
    timeout_clr = 1'b0;
    #1;
    check_eq("wd_cleared", timeout, 1'b0);

    // Ready coinciding with expiry: real response wins
    @(negedge clk);
    req_valid = 2'b01;
    for (int t = 1; t < 8; t++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("co_ready_%0d", t), req_ready, 2'b00);
    end
    @(negedge clk);
    tgt_ready = 1'b1; tgt_rdata = 32'hCAFE_0000;
    #1;
    check_eq("co_ready", req_ready, 2'b01);
    check_eq("co_rdata", req_rdata[0], 32'hCAFE_0000);
    check_eq("co_error", req_error, 2'b00);
    @(negedge clk);
    req_valid = 2'b00; tgt_ready = 1'b0;
    #1;
    check_eq("co_no_timeout", timeout, 1'b0);
`else
    // Without the watchdog BUSY waits indefinitely
    @(negedge clk);
    req_valid = 2'b01; timeout_clr = 1'b1;
    for (int t = 1; t < 13; t++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("nw_ready_%0d", t), req_ready, 2'b00);
      check_eq($sformatf("nw_busy_%0d", t), busy, 1'b1);
      check_eq($sformatf("nw_timeout_%0d", t), timeout, 1'b0);
    end
    @(negedge clk);
    tgt_ready = 1'b1; tgt_rdata = 32'hCAFE_0000; timeout_clr = 1'b0;
    #1;
    check_eq("nw_ready", req_ready, 2'b01);
    check_eq("nw_rdata", req_rdata[0], 32'hCAFE_0000);
    @(negedge clk);
    req_valid = 2'b00; tgt_ready = 1'b0;
`endif

    // Reset mid-BUSY with pointer at 1; after release requester 0 wins
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    tgt_ready = 1'b1;
    #1;
    check_eq("mr_grant1", grant, 2'b10);
    check_eq("mr_ready_pre", req_ready, 2'b10);
    rst_i = 1'b1;
    #1;
    check_eq("mr_tgt_valid", tgt_valid, 1'b0);
    check_eq("mr_ready", req_ready, 2'b00);
    check_eq("mr_grant", grant, 2'b00);
    check_eq("mr_busy", busy, 1'b0);
    @(negedge clk);
    rst_i = 1'b0; tgt_ready = 1'b0;
    #1;
    check_eq("mr_idle", grant, 2'b00);
    @(negedge clk);
    #1;
    check_eq("mr_first_grant", grant, 2'b01);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
